rr_mux_sel_gen: RTL and testbench

//   Round-robin arbiter driving the 3:1 data mux stage (inputs D0/D1/D2, selects S1/S0).

---
 rtl/rr_mux_sel_gen_pkg.sv | 37 +++
 rtl/rr_mux_sel_gen_pick.sv | 35 +++
 rtl/rr_mux_sel_gen.sv | 122 ++++++++++++
 tb/tb_rr_mux_sel_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_sel_gen_pkg.sv
// Shared encodings and helpers for the round-robin 3:1 mux select generator.
// Optional RR_LOCK_EN build macro enables grant locking in the top.
package rr_mux_pkg;

    localparam int NUM_SRC = 3;

    localparam logic [1:0] SEL_D0 = 2'b00;
    localparam logic [1:0] SEL_D1 = 2'b01;
    localparam logic [1:0] SEL_D2 = 2'b10;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    // Modulo-3 increment of a source index.
    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i >= 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic [1:0] idx_to_sel(input logic [1:0] i);
        case (i)
            2'd1:    return SEL_D1;
            2'd2:    return SEL_D2;
            default: return SEL_D0;
        endcase
    endfunction

    function automatic logic [1:0] sel_to_idx(input logic [1:0] s);
        case (s)
            SEL_D1:  return 2'd1;
            SEL_D2:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/rr_mux_sel_gen_pick.sv
// Combinational round-robin pick: first requester at or after ptr, mod 3.
// Produces a one-hot pick vector and the matching source index.
module rr_pick
    import rr_mux_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_SRC-1:0] pick,
    output logic [1:0]         idx,
    output logic               any
);

    logic [3:0] req_ext;
    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;

    always_comb begin
        req_ext = {1'b0, req};
        c0      = (ptr == 2'd3) ? 2'd0 : ptr;
        c1      = next_idx(c0);
        c2      = next_idx(c1);
        any     = |req;
        idx     = c0;
        if (!req_ext[c0]) begin
            if (req_ext[c1]) begin
                idx = c1;
            end else if (req_ext[c2]) begin
                idx = c2;
            end
        end
        pick = any ? (3'b001 << idx) : 3'b000;
    end

endmodule

// File: rtl/rr_mux_sel_gen.sv
// Round-robin arbiter driving 3:1 mux selects and capturing the selected data.
// Define RR_LOCK_EN to let lock hold the current grant across transfers.
module rr_mux_sel_gen
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic [2:0]       gnt,
    output logic             s1,
    output logic             s0,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             lock
);

    state_t     state;
    state_t     state_n;
    logic [1:0] ptr;
    logic [1:0] ptr_n;
    logic [1:0] ptr_acc;
    logic [1:0] pick_ptr;
    logic [1:0] sel;
    logic [1:0] cur_idx;
    logic [2:0] pick;
    logic [1:0] pick_idx;
    logic       pick_any;
    logic       accept;
    logic       load;
    logic       go_idle;
    logic [WIDTH-1:0] dsel;

    assign accept  = out_valid & out_ready;
    assign cur_idx = sel_to_idx(sel);

`ifdef RR_LOCK_EN
    assign ptr_acc = lock ? cur_idx : next_idx(cur_idx);
`else
    logic unused_lock;
    assign unused_lock = lock;
    assign ptr_acc     = next_idx(cur_idx);
`endif

    // A busy accept re-arbitrates against the already-advanced pointer.
    assign pick_ptr = (state == BUSY && accept) ? ptr_acc : ptr;

    rr_pick u_pick (
        .req  (req),
        .ptr  (pick_ptr),
        .pick (pick),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_comb begin
        case (pick_idx)
            2'd1:    dsel = d1;
            2'd2:    dsel = d2;
            default: dsel = d0;
        endcase
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        load    = 1'b0;
        go_idle = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    load    = 1'b1;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (accept) begin
                    ptr_n = ptr_acc;
                    if (pick_any) begin
                        load = 1'b1;
                    end else begin
                        go_idle = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            gnt       <= 3'b000;
            sel       <= SEL_D0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            if (load) begin
                gnt       <= pick;
                sel       <= idx_to_sel(pick_idx);
                out_data  <= dsel;
                out_valid <= 1'b1;
            end else if (go_idle) begin
                gnt       <= 3'b000;
                out_valid <= 1'b0;
            end
        end
    end

    assign s1 = sel[1];
    assign s0 = sel[0];

endmodule

// File: tb/tb_rr_mux_sel_gen.sv
// Directed bench for rr_mux_sel_gen with a per-cycle reference model.
// Build with RR_LOCK_EN defined to exercise grant locking.
module tb_rr_mux_sel_gen;

    localparam int W = 1;
`ifdef RR_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   req;
    logic [W-1:0] d0, d1, d2;
    logic [2:0]   gnt;
    logic         s1, s0;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         lock;
    bit           chk_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    rr_mux_sel_gen #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .gnt       (gnt),
        .s1        (s1),
        .s0        (s0),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lock      (lock)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: what the outputs must be, from the arbitration rules.
    typedef struct {
        bit           busy;
        int           ptr;
        int           src;
        logic [2:0]   gnt;
        logic [1:0]   sel;
        logic [W-1:0] data;
        bit           valid;
    } mstate_t;

    mstate_t m = '{default: 0};

    function automatic logic [W-1:0] src_data(input int i);
        if (i == 0) return d0;
        if (i == 1) return d1;
        return d2;
    endfunction

    function automatic mstate_t mstep(input mstate_t s);
        mstate_t n   = s;
        bit      arb = 1'b0;
        if (!s.busy) begin
            arb = (req != 3'b000);
        end else if (s.valid && out_ready) begin
            n.ptr = (LOCK_ON && lock) ? s.src : (s.src + 1) % 3;
            if (req != 3'b000) begin
                arb = 1'b1;
            end else begin
                n.busy  = 1'b0;
                n.valid = 1'b0;
                n.gnt   = 3'b000;
            end
        end
        if (arb) begin
            for (int k = 2; k >= 0; k--) begin
                if (req[(n.ptr + k) % 3]) n.src = (n.ptr + k) % 3;
            end
            n.gnt   = 3'(1 << n.src);
            n.sel   = 2'(n.src);
            n.data  = src_data(n.src);
            n.valid = 1'b1;
            n.busy  = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{default: 0};
        else        m <= mstep(m);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_gnt", 32'(gnt), 32'(m.gnt));
            check("model_sel", 32'({s1, s0}), 32'(m.sel));
            check("model_valid", 32'(out_valid), 32'(m.valid));
            check("model_data", 32'(out_data), 32'(m.data));
            check("sel_legal", 32'({s1, s0} == 2'b11), 32'd0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input string name, input logic [2:0] g,
                              input logic [1:0] sl, input logic v,
                              input logic [W-1:0] dt);
        check({name, "_gnt"}, 32'(gnt), 32'(g));
        check({name, "_sel"}, 32'({s1, s0}), 32'(sl));
        check({name, "_valid"}, 32'(out_valid), 32'(v));
        check({name, "_data"}, 32'(out_data), 32'(dt));
    endtask

    logic [2:0] rr_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [1:0] rr_s [6] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
    logic [W-1:0] rr_d [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
`ifdef RR_LOCK_EN
    logic [2:0] lk_g [3] = '{3'b100, 3'b100, 3'b100};
    logic [1:0] lk_s [3] = '{2'b10, 2'b10, 2'b10};
    logic [W-1:0] lk_d [3] = '{1'b1, 1'b1, 1'b1};
`else
    logic [2:0] lk_g [3] = '{3'b001, 3'b010, 3'b100};
    logic [1:0] lk_s [3] = '{2'b00, 2'b01, 2'b10};
    logic [W-1:0] lk_d [3] = '{1'b0, 1'b0, 1'b1};
`endif

    initial begin
        rst_n = 1'b1;
        req = 3'b000;
        d0 = '0; d1 = '0; d2 = '0;
        out_ready = 1'b0;
        lock = 1'b0;
        #1 rst_n = 1'b0;
        #2 chk_en = 1'b1;
        cyc(2);
        expect_out("reset", 3'b000, 2'b00, 1'b0, 1'b0);
        rst_n = 1'b1;

        // single request from source 1, ptr=0
        req = 3'b010; d1 = 1'b1; out_ready = 1'b1;
        cyc(1);
        expect_out("t2_grant", 3'b010, 2'b01, 1'b1, 1'b1);
        req = 3'b000; d1 = 1'b0;
        cyc(1);
        expect_out("t2_idle", 3'b000, 2'b01, 1'b0, 1'b1);

        // ptr=2, req=011 wraps to source 0, then ptr=1 favours source 1
        req = 3'b011; d0 = 1'b1; d1 = 1'b0;
        cyc(1);
        expect_out("t5_wrap", 3'b001, 2'b00, 1'b1, 1'b1);
        d0 = 1'b0; d1 = 1'b1;
        cyc(1);
        expect_out("t5_ptr", 3'b010, 2'b01, 1'b1, 1'b1);
        req = 3'b000;
        cyc(1);
        expect_out("t5_idle", 3'b000, 2'b01, 1'b0, 1'b1);

        // ptr=2: one transfer from source 2 brings ptr back to 0
        req = 3'b100; d2 = 1'b1; d1 = 1'b0;
        cyc(1);
        expect_out("pre3_grant", 3'b100, 2'b10, 1'b1, 1'b1);
        req = 3'b000;
        cyc(1);
        expect_out("pre3_idle", 3'b000, 2'b10, 1'b0, 1'b1);

        // all requesting, always ready: strict rotation, no bubbles
        req = 3'b111; d0 = 1'b1; d1 = 1'b0; d2 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            expect_out($sformatf("t3_rr%0d", k), rr_g[k], rr_s[k],
                       1'b1, rr_d[k]);
        end
        req = 3'b000;
        cyc(1);
        expect_out("t3_idle", 3'b000, 2'b10, 1'b0, 1'b1);

        // backpressure: outputs hold while not ready
        req = 3'b001; d0 = 1'b1; d2 = 1'b0; out_ready = 1'b0;
        cyc(1);
        expect_out("t4_grant", 3'b001, 2'b00, 1'b1, 1'b1);
        req = 3'b000; d0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            expect_out($sformatf("t4_hold%0d", k), 3'b001, 2'b00,
                       1'b1, 1'b1);
        end
        out_ready = 1'b1;
        cyc(1);
        expect_out("t4_accept", 3'b000, 2'b00, 1'b0, 1'b1);

        // ptr=1: move ptr to 2, then lock on source 2
        req = 3'b010; d1 = 1'b1;
        cyc(1);
        expect_out("pre6_grant", 3'b010, 2'b01, 1'b1, 1'b1);
        req = 3'b000; d1 = 1'b0;
        cyc(1);
        req = 3'b111; lock = 1'b1; d0 = 1'b0; d1 = 1'b0; d2 = 1'b1;
        cyc(1);
        expect_out("t6_first", 3'b100, 2'b10, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            expect_out($sformatf("t6_lock%0d", k), lk_g[k], lk_s[k],
                       1'b1, lk_d[k]);
        end
        lock = 1'b0;
        cyc(1);
        expect_out("t7_unlock", 3'b001, 2'b00, 1'b1, 1'b0);
        req = 3'b000;
        cyc(1);
        expect_out("t7_idle", 3'b000, 2'b00, 1'b0, 1'b0);

        // asynchronous reset while a transfer is pending
        req = 3'b010; d1 = 1'b1; out_ready = 1'b0;
        cyc(1);
        expect_out("t1_busy", 3'b010, 2'b01, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1 expect_out("t1_reset", 3'b000, 2'b00, 1'b0, 1'b0);
        req = 3'b000;
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        expect_out("t1_after", 3'b000, 2'b00, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
